// File: rtl/fpu_issue_seq.sv
// FPU issue sequencer: one op in flight, operand hold, result capture.
// Optional FPU_SEQ_BYPASS_EN: retire and accept in the same DONE cycle.
module fpu_issue_seq #(
   parameter int FLEN     = 32,
   parameter int LAT_ADD  = 2,
   parameter int LAT_MUL  = 3,
   parameter int LAT_DIV  = 8,
   parameter int LAT_SQRT = 8,
   parameter int LAT_FMA  = 4,
   parameter int LAT_MISC = 1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [5:0]      req_op,
   input  logic [FLEN-1:0] req_rs1,
   input  logic [FLEN-1:0] req_rs2,
   input  logic [FLEN-1:0] req_rs3,
   input  logic [4:0]      req_rd,
   input  logic [31:0]     req_fcsr,
   output logic [5:0]      fpu_operation,
   output logic [FLEN-1:0] fpu_rs1,
   output logic [FLEN-1:0] fpu_rs2,
   output logic [FLEN-1:0] fpu_rs3,
   output logic [31:0]     fpu_fcsr,
   input  logic [FLEN-1:0] fpu_result,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [FLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_int,
   output logic            wb_illegal,
   output logic            busy
);

   if (LAT_ADD > 255 || LAT_MUL > 255 || LAT_DIV > 255 ||
       LAT_SQRT > 255 || LAT_FMA > 255 || LAT_MISC > 255) begin : g_lat_range
      $error("fpu_issue_seq: latency parameters must not exceed 255");
   end

   // Counter preload is latency minus one; a latency of 0 behaves as 1.
   localparam logic [7:0] L_ADD  = 8'((LAT_ADD  < 1) ? 0 : LAT_ADD  - 1);
   localparam logic [7:0] L_MUL  = 8'((LAT_MUL  < 1) ? 0 : LAT_MUL  - 1);
   localparam logic [7:0] L_DIV  = 8'((LAT_DIV  < 1) ? 0 : LAT_DIV  - 1);
   localparam logic [7:0] L_SQRT = 8'((LAT_SQRT < 1) ? 0 : LAT_SQRT - 1);
   localparam logic [7:0] L_FMA  = 8'((LAT_FMA  < 1) ? 0 : LAT_FMA  - 1);
   localparam logic [7:0] L_MISC = 8'((LAT_MISC < 1) ? 0 : LAT_MISC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [5:0]      op_q,   op_d;
   logic [FLEN-1:0] rs1_q,  rs1_d;
   logic [FLEN-1:0] rs2_q,  rs2_d;
   logic [FLEN-1:0] rs3_q,  rs3_d;
   logic [31:0]     fcsr_q, fcsr_d;
   logic [4:0]      rd_q,   rd_d;
   logic [7:0]      cnt_q,  cnt_d;
   logic [FLEN-1:0] data_q, data_d;
   logic            ill_q,  ill_d;

   logic accept;
   logic retire;
   logic req_ill;

   function automatic logic [7:0] lat_m1(input logic [5:0] op);
      logic [7:0] l;
      l = 8'd0;
      if (op <= 6'd1)
         l = L_ADD;
      else if (op == 6'd2)
         l = L_MUL;
      else if (op == 6'd3)
         l = L_DIV;
      else if (op <= 6'd16)
         l = L_MISC;
      else if (op == 6'd17)
         l = L_SQRT;
      else if (op <= 6'd21)
         l = L_FMA;
      return l;
   endfunction

   function automatic logic is_int(input logic [5:0] op);
      return (op == 6'd6)  || (op == 6'd7)  || (op == 6'd8) ||
             (op == 6'd14) || (op == 6'd15) || (op == 6'd16);
   endfunction

   assign req_ill = (req_op > 6'd21);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept)
                  state_d = req_ill ? DONE : EXEC;
            end
            EXEC: begin
               if (cnt_q == 8'd0)
                  state_d = DONE;
            end
            DONE: begin
               if (accept)
                  state_d = req_ill ? DONE : EXEC;
               else if (retire)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are forced low while reset is held, including req_ready.
   always_comb begin
      req_ready = 1'b0;
      wb_valid  = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: req_ready = 1'b1;
         EXEC: busy = 1'b1;
         DONE: begin
            busy     = 1'b1;
            wb_valid = 1'b1;
`ifdef FPU_SEQ_BYPASS_EN
            req_ready = wb_ready;
`endif
         end
         default: ;
      endcase
      req_ready = req_ready & resetn & ~flush;
      accept    = req_valid & req_ready;
      retire    = wb_valid & wb_ready;
      wb_int    = wb_valid & is_int(op_q);
   end

   always_comb begin
      op_d   = op_q;
      rs1_d  = rs1_q;
      rs2_d  = rs2_q;
      rs3_d  = rs3_q;
      fcsr_d = fcsr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      ill_d  = ill_q;
      if (flush) begin
         cnt_d = 8'd0;
         ill_d = 1'b0;
      end else begin
         if (state_q == EXEC) begin
            if (cnt_q == 8'd0)
               data_d = fpu_result;
            else
               cnt_d = cnt_q - 8'd1;
         end
         if (retire)
            ill_d = 1'b0;
         if (accept) begin
            op_d   = req_op;
            rs1_d  = req_rs1;
            rs2_d  = req_rs2;
            rs3_d  = req_rs3;
            fcsr_d = req_fcsr;
            rd_d   = req_rd;
            cnt_d  = lat_m1(req_op);
            data_d = '0;
            ill_d  = req_ill;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q   <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rs3_q  <= '0;
         fcsr_q <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         ill_q  <= 1'b0;
      end else begin
         op_q   <= op_d;
         rs1_q  <= rs1_d;
         rs2_q  <= rs2_d;
         rs3_q  <= rs3_d;
         fcsr_q <= fcsr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         ill_q  <= ill_d;
      end
   end

   assign fpu_operation = op_q;
   assign fpu_rs1       = rs1_q;
   assign fpu_rs2       = rs2_q;
   assign fpu_rs3       = rs3_q;
   assign fpu_fcsr      = fcsr_q;
   assign wb_data       = data_q;
   assign wb_rd         = rd_q;
   assign wb_illegal    = ill_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Scoreboard bench for fpu_issue_seq: directed cases then random ops.
module tb_fpu_issue_seq;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_op = '0;
   logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
   logic [4:0]  req_rd = '0;
   logic [31:0] req_fcsr = '0;
   logic [5:0]  fpu_operation;
   logic [31:0] fpu_rs1, fpu_rs2, fpu_rs3, fpu_fcsr;
   logic [31:0] fpu_result;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_int, wb_illegal, busy;

   int tests = 0;
   int fails = 0;
   int wbr_mode = 1;
   logic        fix_en = 1'b0;
   logic [31:0] fix_val = '0;
   logic [31:0] cyc = '0;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wint;
      logic        ill;
      logic [31:0] due;
      bit          seen;
   } sb_t;
   sb_t sbq[$];

   fpu_issue_seq dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
      .req_rd(req_rd), .req_fcsr(req_fcsr),
      .fpu_operation(fpu_operation), .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2),
      .fpu_rs3(fpu_rs3), .fpu_fcsr(fpu_fcsr), .fpu_result(fpu_result),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_int(wb_int), .wb_illegal(wb_illegal), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   // Stand-in FPU: result depends on held operands and the current cycle,
   // so a capture on the wrong edge or from wrong operands is visible.
   function automatic logic [31:0] fmodel(input logic [5:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] c, input logic [31:0] f);
      return (a ^ {b[15:0], b[31:16]}) + (c * 32'd3) + (f ^ ({26'd0, op} * 32'h9E3779B1));
   endfunction

   assign fpu_result = fix_en ? fix_val :
      (fmodel(fpu_operation, fpu_rs1, fpu_rs2, fpu_rs3, fpu_fcsr) ^ cyc);

   function automatic int lat_of(input logic [5:0] op);
      if (op <= 1) return 2;
      if (op == 2) return 3;
      if (op == 3 || op == 17) return 8;
      if (op >= 18 && op <= 21) return 4;
      return 1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Called just after a rising edge; returns the accepting edge index.
   task automatic issue(input logic [5:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] c,
      input logic [4:0] rd, input logic [31:0] fc, output logic [31:0] n);
      bit got;
      sb_t e;
      int l;
      got = 0;
      n = '0;
      req_valid = 1'b1;
      req_op = op; req_rs1 = a; req_rs2 = b; req_rs3 = c;
      req_rd = rd; req_fcsr = fc;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         chk("issue_timeout", 64'(got), 64'd1);
         req_valid = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      n = cyc;
      req_valid = 1'b0;
      l = lat_of(op);
      e.ill  = (op > 6'd21);
      e.rd   = rd;
      e.wint = op inside {6'd6, 6'd7, 6'd8, 6'd14, 6'd15, 6'd16};
      e.seen = 0;
      if (e.ill) begin
         e.due  = n;
         e.data = '0;
      end else begin
         e.due  = n + 32'(l);
         e.data = fix_en ? fix_val : (fmodel(op, a, b, c, fc) ^ (n + 32'(l) - 32'd1));
      end
      sbq.push_back(e);
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if (sbq.size() == 0) begin
            ok = 1;
            break;
         end
      end
      chk("drain", 64'(ok), 64'd1);
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (resetn && wb_valid) begin
         if (sbq.size() == 0) begin
            chk("wb_unexpected", 64'(wb_valid), 64'd0);
         end else begin
            e = sbq[0];
            if (!e.seen) begin
               chk("wb_due", 64'(cyc), 64'(e.due));
               e.seen = 1;
               sbq[0] = e;
            end
            chk("wb_data", 64'(wb_data), 64'(e.data));
            chk("wb_rd", 64'(wb_rd), 64'(e.rd));
            chk("wb_int", 64'(wb_int), 64'(e.wint));
            chk("wb_illegal", 64'(wb_illegal), 64'(e.ill));
            if (wb_ready) void'(sbq.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (wbr_mode == 0) wb_ready = 1'($urandom_range(0, 1));
         else if (wbr_mode == 1) wb_ready = 1'b0;
         else wb_ready = 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] n1, n2;
      int gap;
      logic [5:0] op;

      #3;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_fpu_op", 64'(fpu_operation), 64'd0);
      chk("rst_wb_data", 64'(wb_data), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_rel_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;

      // fadd with fixed FPU answer
      wbr_mode = 2; wb_ready = 1'b1;
      fix_en = 1'b1; fix_val = 32'h40400000;
      issue(6'd0, 32'h3F800000, 32'h40000000, 32'h0, 5'd3, 32'h0, n1);
      chk("t1_fpu_rs1", 64'(fpu_rs1), 64'h3F800000);
      chk("t1_fpu_rs2", 64'(fpu_rs2), 64'h40000000);
      wait_drain();

      // feq held in DONE by wb_ready low
      wbr_mode = 1; wb_ready = 1'b0;
      fix_val = 32'h1;
      issue(6'd16, 32'h12345678, 32'h12345678, 32'h0, 5'd9, 32'h0, n1);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t2_valid", 64'(wb_valid), 64'd1);
         chk("t2_data", 64'(wb_data), 64'd1);
         chk("t2_ready", 64'(req_ready), 64'd0);
         chk("t2_int", 64'(wb_int), 64'd1);
      end
      @(posedge clk); #1;
      wbr_mode = 2; wb_ready = 1'b1;
      wait_drain();
      fix_en = 1'b0;

      // illegal opcode
      wbr_mode = 1; wb_ready = 1'b0;
      issue(6'd40, 32'hAAAA5555, 32'h1, 32'h2, 5'd17, 32'h0, n1);
      @(negedge clk);
      chk("t3_valid", 64'(wb_valid), 64'd1);
      chk("t3_ill", 64'(wb_illegal), 64'd1);
      chk("t3_data", 64'(wb_data), 64'd0);
      @(posedge clk); #1;
      wbr_mode = 2; wb_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_ill_clr", 64'(wb_illegal), 64'd0);
      chk("t3_valid_clr", 64'(wb_valid), 64'd0);
      @(posedge clk); #1;

      // fdiv flushed at the fourth cycle
      issue(6'd3, 32'h11111111, 32'h22222222, 32'h0, 5'd4, 32'h000000E0, n1);
      repeat (3) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      sbq.delete();
      @(negedge clk);
      chk("t4_ready", 64'(req_ready), 64'd1);
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_fpu_op", 64'(fpu_operation), 64'd3);
      repeat (12) @(negedge clk);
      @(posedge clk); #1;

      // reset during fsqrt
      issue(6'd17, 32'hCAFEF00D, 32'h0, 32'h0, 5'd21, 32'h0, n1);
      repeat (3) begin @(posedge clk); #1; end
      #2;
      resetn = 1'b0;
      #1;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_ready", 64'(req_ready), 64'd0);
      chk("t5_valid", 64'(wb_valid), 64'd0);
      chk("t5_fpu_op", 64'(fpu_operation), 64'd0);
      chk("t5_fpu_rs1", 64'(fpu_rs1), 64'd0);
      chk("t5_wb_rd", 64'(wb_rd), 64'd0);
      sbq.delete();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("t5_idle_ready", 64'(req_ready), 64'd1);
      chk("t5_idle_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // back-to-back fmul
      issue(6'd2, 32'h1, 32'h2, 32'h3, 5'd1, 32'h0, n1);
      issue(6'd2, 32'h4, 32'h5, 32'h6, 5'd2, 32'h0, n2);
`ifdef FPU_SEQ_BYPASS_EN
      chk("t6_spacing", 64'(n2 - n1), 64'd4);
`else
      chk("t6_spacing", 64'(n2 - n1), 64'd5);
`endif
      wait_drain();

      // random ops with random stalls and occasional flushes
      wbr_mode = 0;
      for (int i = 0; i < 250; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin @(posedge clk); #1; end
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(22, 63))
                                          : 6'($urandom_range(0, 21));
         issue(op, $urandom, $urandom, $urandom, 5'($urandom), $urandom, n1);
         if ($urandom_range(0, 7) == 0) begin
            gap = $urandom_range(0, 9);
            repeat (gap) begin @(posedge clk); #1; end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            sbq.delete();
         end
      end
      wbr_mode = 2; wb_ready = 1'b1;
      wait_drain();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
